// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
// Imported by the picker and by the top-level FSM.
package reg_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width of an index into n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo N_REQ, found by scanning a doubled copy of the request vector.
module rr_pick
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    win,
  output logic [N_REQ-1:0] onehot
);

  logic [2*N_REQ-1:0] dbl;

  // Descending scan so the position closest to ptr is the last one written.
  always_comb begin
    dbl    = {req, req};
    any    = 1'b0;
    win    = '0;
    onehot = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (dbl[int'(ptr) + k]) begin
        any = 1'b1;
        win = IW'((int'(ptr) + k) % N_REQ);
      end
    end
    if (any) begin
      onehot[win] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that is the sole writer of a shared WIDTH-bit register,
// granting one requester at a time with a tenure capped at MAX_HOLD cycles.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_bar
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = $clog2(MAX_HOLD + 1);

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [CW-1:0]      cnt;

  logic [IW-1:0]      rel_ptr;
  logic               owner_req;
  logic               owner_lock;
  logic [WIDTH-1:0]   owner_word;
  logic               stay;

  logic               idle_any;
  logic [IW-1:0]      idle_win;
  logic [N_REQ-1:0]   idle_oh;
  logic               rel_any;
  logic [IW-1:0]      rel_win;
  logic [N_REQ-1:0]   rel_oh;

  assign rel_ptr    = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
  assign owner_req  = req[owner];
  assign owner_lock = lock[owner];
  assign owner_word = wdata[owner*WIDTH +: WIDTH];
  assign stay       = owner_req && owner_lock && (cnt < CW'(MAX_HOLD));

  // Fresh arbitration from idle uses the stored pointer.
  rr_pick #(.N_REQ(N_REQ)) u_pick_idle (
    .req    (req),
    .ptr    (ptr),
    .any    (idle_any),
    .win    (idle_win),
    .onehot (idle_oh)
  );

  // Hand-over arbitration starts just past the releasing owner, which leaves
  // that owner last in line so it only wins again when nobody else asks.
  rr_pick #(.N_REQ(N_REQ)) u_pick_rel (
    .req    (req),
    .ptr    (rel_ptr),
    .any    (rel_any),
    .win    (rel_win),
    .onehot (rel_oh)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_any) begin
            state <= GRANT;
            gnt   <= idle_oh;
            owner <= idle_win;
            cnt   <= CW'(1);
          end
        end
        GRANT, HOLD: begin
          if (owner_req) begin
            q <= owner_word;
          end
          if (stay) begin
            state <= HOLD;
            cnt   <= cnt + CW'(1);
          end else begin
            ptr <= rel_ptr;
            if (rel_any) begin
              state <= GRANT;
              gnt   <= rel_oh;
              owner <= rel_win;
              cnt   <= CW'(1);
            end else begin
              state <= IDLE;
              gnt   <= '0;
              cnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign q_bar = ~q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter with N_REQ=4, WIDTH=8, MAX_HOLD=4.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_reg_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  q_bar;

  int pass_cnt = 0;
  int total_cnt = 0;

  reg_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q),
    .q_bar (q_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    wdata[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    lock  = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req   = '0;
    lock  = '0;
    wdata = '0;
    reset = 1'b0;
    #12;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b want %b", gnt, 4'b0000);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want %b", busy, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (owner !== 2'd0) $display("[TB] FAIL reset_owner: got %0d want %0d", owner, 0);
    else pass_cnt++;
    total_cnt++;
    if (q !== 8'h00) $display("[TB] FAIL reset_q: got %h want %h", q, 8'h00);
    else pass_cnt++;
    total_cnt++;
    if (q_bar !== 8'hFF) $display("[TB] FAIL reset_q_bar: got %h want %h", q_bar, 8'hFF);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || gnt !== 4'b0000) $display("[TB] FAIL reset_idle: got busy=%b gnt=%b want busy=0 gnt=0000", busy, gnt);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    set_word(1, 8'hA5);
    req = 4'b0010;
    tick();
    total_cnt++;
    if (gnt !== 4'b0010) $display("[TB] FAIL single_gnt: got %b want %b", gnt, 4'b0010);
    else pass_cnt++;
    total_cnt++;
    if (owner !== 2'd1 || busy !== 1'b1) $display("[TB] FAIL single_owner_busy: got owner=%0d busy=%b want owner=1 busy=1", owner, busy);
    else pass_cnt++;
    total_cnt++;
    if (q !== 8'h00) $display("[TB] FAIL single_q_early: got %h want %h", q, 8'h00);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (q !== 8'hA5 || q_bar !== 8'h5A) $display("[TB] FAIL single_q: got q=%h q_bar=%h want q=a5 q_bar=5a", q, q_bar);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || gnt !== 4'b0000) $display("[TB] FAIL single_release: got busy=%b gnt=%b want busy=0 gnt=0000", busy, gnt);
    else pass_cnt++;
    total_cnt++;
    if (q !== 8'hA5) $display("[TB] FAIL single_q_hold: got %h want %h", q, 8'hA5);
    else pass_cnt++;
    // Pointer now sits at 2, so requester 3 beats requester 0.
    set_word(0, 8'h0C);
    set_word(3, 8'h3C);
    req = 4'b1001;
    tick();
    total_cnt++;
    if (gnt !== 4'b1000) $display("[TB] FAIL single_ptr: got %b want %b", gnt, 4'b1000);
    else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_contention_and_lock();
    logic [3:0] exp_gnt;
    logic [7:0] exp_q;
    do_reset();
    for (int i = 0; i < 4; i++) set_word(i, 8'h10 + 8'(i));
    req = 4'b1111;
    tick();
    total_cnt++;
    if (gnt !== 4'b0001) $display("[TB] FAIL contend_first: got %b want %b", gnt, 4'b0001);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_gnt = 4'b0001 << (i % 4);
      exp_q   = 8'h10 + 8'(i - 1);
      total_cnt++;
      if (gnt !== exp_gnt || q !== exp_q) $display("[TB] FAIL contend_step%0d: got gnt=%b q=%h want gnt=%b q=%h", i, gnt, q, exp_gnt, exp_q);
      else pass_cnt++;
    end
    // Owner 0 releases into ptr=1, so locked requester 2 wins over 0.
    req  = 4'b0101;
    lock = 4'b0100;
    set_word(2, 8'hC0);
    tick();
    total_cnt++;
    if (gnt !== 4'b0100 || q !== 8'h10) $display("[TB] FAIL lock_start: got gnt=%b q=%h want gnt=0100 q=10", gnt, q);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      set_word(2, 8'hC0 + 8'(k));
      tick();
      exp_gnt = (k < 3) ? 4'b0100 : 4'b0001;
      exp_q   = 8'hC0 + 8'(k);
      total_cnt++;
      if (gnt !== exp_gnt || q !== exp_q) $display("[TB] FAIL lock_cycle%0d: got gnt=%b q=%h want gnt=%b q=%h", k, gnt, q, exp_gnt, exp_q);
      else pass_cnt++;
    end
  endtask

  task automatic test_withdraw();
    // Continues with owner 0 in its first cycle of tenure.
    req  = 4'b0001;
    lock = 4'b0001;
    set_word(0, 8'h55);
    tick();
    total_cnt++;
    if (gnt !== 4'b0001 || q !== 8'h55) $display("[TB] FAIL withdraw_hold: got gnt=%b q=%h want gnt=0001 q=55", gnt, q);
    else pass_cnt++;
    req  = 4'b0010;
    lock = 4'b0000;
    set_word(0, 8'h77);
    set_word(1, 8'h66);
    tick();
    total_cnt++;
    if (q !== 8'h55) $display("[TB] FAIL withdraw_q: got %h want %h", q, 8'h55);
    else pass_cnt++;
    total_cnt++;
    if (gnt !== 4'b0010 || owner !== 2'd1) $display("[TB] FAIL withdraw_next: got gnt=%b owner=%0d want gnt=0010 owner=1", gnt, owner);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    total_cnt++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h55) $display("[TB] FAIL withdraw_idle: got gnt=%b busy=%b q=%h want gnt=0000 busy=0 q=55", gnt, busy, q);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    set_word(0, 8'h11);
    req  = 4'b0001;
    lock = 4'b0001;
    tick();
    tick();
    total_cnt++;
    if (q !== 8'h11 || busy !== 1'b1) $display("[TB] FAIL rhold_setup: got q=%h busy=%b want q=11 busy=1", q, busy);
    else pass_cnt++;
    #3;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h00 || q_bar !== 8'hFF) $display("[TB] FAIL rhold_async: got gnt=%b busy=%b q=%h q_bar=%h want gnt=0000 busy=0 q=00 q_bar=ff", gnt, busy, q, q_bar);
    else pass_cnt++;
    reset = 1'b0;
    req   = 4'b1000;
    lock  = 4'b0000;
    set_word(3, 8'h99);
    tick();
    total_cnt++;
    if (gnt !== 4'b1000 || owner !== 2'd3) $display("[TB] FAIL rhold_regrant: got gnt=%b owner=%0d want gnt=1000 owner=3", gnt, owner);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (q !== 8'h99) $display("[TB] FAIL rhold_q: got %h want %h", q, 8'h99);
    else pass_cnt++;
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention_and_lock();
    test_withdraw();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
